mem_channel_serializer: RTL and testbench

Memory-side stage downstream of the gpu data-memory channels. Accepts up to NUM_CHANNELS concurrent read/write requests on the gpu's multi-channel valid/ready interface and serializes them onto one single-port synchronous SRAM with 1-cycle read latency. Arbitration is round-robin across channels, and each serviced request gets exactly one ready pulse.

---
 rtl/mem_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_channel_serializer.sv | 139 +++++++++++++
 tb/tb_mem_channel_serializer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-side serializer and related arbiters.
// Exposes the request-processing state type so other controllers can reuse it.
package mem_pkg;

    // Serializer request flow: grant in IDLE, one SRAM cycle in ACCESS,
    // read data registered in CAPTURE, ready pulse in RESPOND.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } memser_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping. Ports: eligible (request mask), ptr (start index),
// grant (one-hot winner), found (any winner).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found
);

    // First pass looks at indices >= ptr; if none, the second pass takes
    // the lowest eligible index, which is the wrapped-around winner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && eligible[j] && (PW'(j) >= ptr)) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && eligible[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_channel_serializer.sv
// Serializes multi-channel read/write requests onto one single-port SRAM
// (1-cycle read latency) with round-robin arbitration.
// Ports: clk, reset (sync, active-low); per-channel read/write valid,
// address, data and ready pulses; sram_en/we/addr/wdata/rdata; busy.
module mem_channel_serializer
    import mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] ch_read_valid,
    input  logic [ADDR_BITS-1:0]    ch_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] ch_read_ready,
    output logic [DATA_BITS-1:0]    ch_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] ch_write_valid,
    input  logic [ADDR_BITS-1:0]    ch_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    ch_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] ch_write_ready,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [ADDR_BITS-1:0]    sram_addr,
    output logic [DATA_BITS-1:0]    sram_wdata,
    input  logic [DATA_BITS-1:0]    sram_rdata,
    output logic                    busy
);

    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    memser_state_t           state;
    logic [CW-1:0]           cur_ch;
    logic                    cur_we;
    logic [CW-1:0]           rr_ptr;
    logic [NUM_CHANNELS-1:0] served;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] grant;
    logic                    found;
    logic [CW-1:0]           grant_idx;
    logic                    grant_we;

    // served masks a channel whose request was just answered but whose
    // valid may still be high for a cycle or more.
    assign eligible = (ch_read_valid | ch_write_valid) & ~served;

    rr_arbiter #(
        .N  (NUM_CHANNELS),
        .PW (CW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .found    (found)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant[i]) grant_idx = CW'(i);
        end
    end

    // A channel with both valids is served as a write first.
    assign grant_we = ch_write_valid[grant_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            cur_ch         <= '0;
            cur_we         <= 1'b0;
            rr_ptr         <= '0;
            served         <= '0;
            sram_en        <= 1'b0;
            sram_we        <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ch_read_data[c] <= '0;
            end
        end else begin
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            sram_en        <= 1'b0;
            sram_we        <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (!ch_read_valid[c] && !ch_write_valid[c]) begin
                    served[c] <= 1'b0;
                end
            end
            unique case (state)
                IDLE: begin
                    if (found) begin
                        cur_ch     <= grant_idx;
                        cur_we     <= grant_we;
                        sram_en    <= 1'b1;
                        sram_we    <= grant_we;
                        sram_addr  <= grant_we ? ch_write_address[grant_idx]
                                               : ch_read_address[grant_idx];
                        sram_wdata <= grant_we ? ch_write_data[grant_idx] : '0;
                        rr_ptr     <= (grant_idx == CW'(NUM_CHANNELS - 1))
                                      ? '0 : grant_idx + 1'b1;
                        state      <= ACCESS;
                        busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cur_we) begin
                        ch_write_ready[cur_ch] <= 1'b1;
                        state                  <= RESPOND;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    ch_read_data[cur_ch]  <= sram_rdata;
                    ch_read_ready[cur_ch] <= 1'b1;
                    state                 <= RESPOND;
                end
                RESPOND: begin
                    // Overrides the clear above when valids are already low.
                    served[cur_ch] <= 1'b1;
                    state          <= IDLE;
                    busy           <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_channel_serializer.sv
// Directed bench for mem_channel_serializer with a behavioural SRAM.
// Each scenario task drives requests and checks ready timing and data.
module tb_mem_channel_serializer;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] ch_read_valid;
    logic [AB-1:0] ch_read_address [NC];
    logic [NC-1:0] ch_read_ready;
    logic [DB-1:0] ch_read_data [NC];
    logic [NC-1:0] ch_write_valid;
    logic [AB-1:0] ch_write_address [NC];
    logic [DB-1:0] ch_write_data [NC];
    logic [NC-1:0] ch_write_ready;
    logic          sram_en;
    logic          sram_we;
    logic [AB-1:0] sram_addr;
    logic [DB-1:0] sram_wdata;
    logic [DB-1:0] sram_rdata;
    logic          busy;

    logic [DB-1:0] mem [256];
    logic          preloaded = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_channel_serializer #(
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .NUM_CHANNELS (NC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ch_read_valid    (ch_read_valid),
        .ch_read_address  (ch_read_address),
        .ch_read_ready    (ch_read_ready),
        .ch_read_data     (ch_read_data),
        .ch_write_valid   (ch_write_valid),
        .ch_write_address (ch_write_address),
        .ch_write_data    (ch_write_data),
        .ch_write_ready   (ch_write_ready),
        .sram_en          (sram_en),
        .sram_we          (sram_we),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata),
        .busy             (busy)
    );

    // SRAM model: preload on the first edge, then 1-cycle read latency.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) begin
                if (i < 4)          mem[i] <= 8'(i);
                else if (i == 'h20) mem[i] <= 8'h11;
                else                mem[i] <= 8'h00;
            end
            sram_rdata <= '0;
            preloaded  <= 1'b1;
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits up to max negedges for any ready bit; rr/wr stay 0 on timeout.
    task automatic wait_any_ready(input int max, output int cyc,
                                  output logic [NC-1:0] rr,
                                  output logic [NC-1:0] wr);
        cyc = 0;
        rr  = '0;
        wr  = '0;
        while (cyc < max && rr == '0 && wr == '0) begin
            @(negedge clk);
            cyc++;
            rr = ch_read_ready;
            wr = ch_write_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ch_read_valid = '1;
        for (int c = 0; c < NC; c++) ch_read_address[c] = 8'(8'h40 + c);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (sram_en !== 1'b0 || ch_read_ready !== '0 ||
                ch_write_ready !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: en=%b rrdy=%b wrdy=%b busy=%b want 0",
                         sram_en, ch_read_ready, ch_write_ready, busy);
            end
        end
        checks++;
        if (ch_read_data[0] !== 8'h00 || ch_read_data[3] !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: d0=%h d3=%h want 00",
                     ch_read_data[0], ch_read_data[3]);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b0 ||
            sram_addr !== 8'h40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: en=%b we=%b addr=%h busy=%b want 1 0 40 1",
                     sram_en, sram_we, sram_addr, busy);
        end
        ch_read_valid = '0;
        do_reset();
        idle(2);
    endtask

    task automatic test_write_read();
        int cyc;
        logic [NC-1:0] rr, wr;
        ch_write_valid[1]   = 1'b1;
        ch_write_address[1] = 8'h10;
        ch_write_data[1]    = 8'hA5;
        @(negedge clk);
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 1'b1 ||
            sram_addr !== 8'h10 || sram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_access: en=%b we=%b addr=%h wd=%h want 1 1 10 a5",
                     sram_en, sram_we, sram_addr, sram_wdata);
        end
        ch_write_address[1] = 8'h55;
        ch_write_data[1]    = 8'h00;
        @(negedge clk);
        checks++;
        if (ch_write_ready !== 4'b0010 || sram_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready: wrdy=%b en=%b want 0010 0",
                     ch_write_ready, sram_en);
        end
        ch_write_valid = '0;
        idle(3);
        ch_read_valid[1]   = 1'b1;
        ch_read_address[1] = 8'h10;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b0010 || wr !== 4'b0000 || cyc !== 3) begin
            errors++;
            $display("FAIL rd_ready: rrdy=%b wrdy=%b cyc=%0d want 0010 0000 3",
                     rr, wr, cyc);
        end
        checks++;
        if (ch_read_data[1] !== 8'hA5) begin
            errors++;
            $display("FAIL rd_data: got %h want a5", ch_read_data[1]);
        end
        ch_read_valid = '0;
        idle(3);
    endtask

    task automatic rr_pass(input int e0, input int e1, input int e2, input int e3);
        int exp_ch [4];
        int cyc;
        logic [NC-1:0] rr, wr;
        exp_ch = '{e0, e1, e2, e3};
        for (int c = 0; c < NC; c++) ch_read_address[c] = 8'(c);
        ch_read_valid = '1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(10, cyc, rr, wr);
            checks++;
            if (rr !== (4'b0001 << exp_ch[k]) || wr !== 4'b0000) begin
                errors++;
                $display("FAIL rr_order[%0d]: rrdy=%b wrdy=%b want ch%0d",
                         k, rr, wr, exp_ch[k]);
            end
            checks++;
            if (ch_read_data[exp_ch[k]] !== 8'(exp_ch[k])) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %h want %h",
                         k, ch_read_data[exp_ch[k]], 8'(exp_ch[k]));
            end
            ch_read_valid = ch_read_valid & ~rr;
        end
        ch_read_valid = '0;
        idle(3);
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [NC-1:0] rr, wr;
        do_reset();
        idle(1);
        rr_pass(0, 1, 2, 3);
        // A lone grant on ch1 moves the pointer to 2.
        ch_write_valid[1]   = 1'b1;
        ch_write_address[1] = 8'h80;
        ch_write_data[1]    = 8'h5A;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (wr !== 4'b0010 || cyc !== 2) begin
            errors++;
            $display("FAIL rr_ptr_set: wrdy=%b cyc=%0d want 0010 2", wr, cyc);
        end
        ch_write_valid = '0;
        idle(3);
        rr_pass(2, 3, 0, 1);
    endtask

    task automatic test_held_valid();
        int cyc, en_cnt, rdy_cnt;
        logic [NC-1:0] rr, wr;
        ch_read_valid[2]   = 1'b1;
        ch_read_address[2] = 8'h02;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b0100 || cyc !== 3) begin
            errors++;
            $display("FAIL held_first: rrdy=%b cyc=%0d want 0100 3", rr, cyc);
        end
        en_cnt  = 0;
        rdy_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (sram_en === 1'b1) en_cnt++;
            if (ch_read_ready !== '0) rdy_cnt++;
        end
        checks++;
        if (en_cnt !== 0 || rdy_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_noreissue: en_cnt=%0d rdy_cnt=%0d busy=%b want 0 0 0",
                     en_cnt, rdy_cnt, busy);
        end
        ch_read_valid[2] = 1'b0;
        @(negedge clk);
        ch_read_valid[2] = 1'b1;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b0100 || cyc !== 3 || ch_read_data[2] !== 8'h02) begin
            errors++;
            $display("FAIL held_reissue: rrdy=%b cyc=%0d d=%h want 0100 3 02",
                     rr, cyc, ch_read_data[2]);
        end
        ch_read_valid = '0;
        idle(3);
    endtask

    task automatic test_same_channel_rw();
        int cyc, en_cnt, rdy_cnt;
        logic [NC-1:0] rr, wr;
        ch_read_valid[0]    = 1'b1;
        ch_read_address[0]  = 8'h20;
        ch_write_valid[0]   = 1'b1;
        ch_write_address[0] = 8'h20;
        ch_write_data[0]    = 8'h22;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (wr !== 4'b0001 || rr !== 4'b0000 || cyc !== 2) begin
            errors++;
            $display("FAIL rw_write_first: wrdy=%b rrdy=%b cyc=%0d want 0001 0000 2",
                     wr, rr, cyc);
        end
        en_cnt  = 0;
        rdy_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (sram_en === 1'b1) en_cnt++;
            if (ch_read_ready !== '0 || ch_write_ready !== '0) rdy_cnt++;
        end
        checks++;
        if (en_cnt !== 0 || rdy_cnt !== 0) begin
            errors++;
            $display("FAIL rw_held: en_cnt=%0d rdy_cnt=%0d want 0 0", en_cnt, rdy_cnt);
        end
        ch_read_valid  = '0;
        ch_write_valid = '0;
        @(negedge clk);
        ch_read_valid[0] = 1'b1;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b0001 || cyc !== 3 || ch_read_data[0] !== 8'h22) begin
            errors++;
            $display("FAIL rw_read_after: rrdy=%b cyc=%0d d=%h want 0001 3 22",
                     rr, cyc, ch_read_data[0]);
        end
        ch_read_valid = '0;
        idle(3);
    endtask

    task automatic test_mid_op_reset();
        int en_cnt, rdy_cnt;
        ch_read_valid[3]   = 1'b1;
        ch_read_address[3] = 8'h03;
        @(negedge clk);
        checks++;
        if (sram_en !== 1'b1 || sram_addr !== 8'h03 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_access: en=%b addr=%h busy=%b want 1 03 1",
                     sram_en, sram_addr, busy);
        end
        reset         = 1'b0;
        ch_read_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sram_en !== 1'b0 || ch_read_ready !== '0) begin
            errors++;
            $display("FAIL midrst_abort: busy=%b en=%b rrdy=%b want 0 0 0000",
                     busy, sram_en, ch_read_ready);
        end
        reset   = 1'b1;
        en_cnt  = 0;
        rdy_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (sram_en === 1'b1) en_cnt++;
            if (ch_read_ready !== '0 || ch_write_ready !== '0) rdy_cnt++;
        end
        checks++;
        if (en_cnt !== 0 || rdy_cnt !== 0 || ch_read_data[3] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_quiet: en_cnt=%0d rdy_cnt=%0d d3=%h want 0 0 00",
                     en_cnt, rdy_cnt, ch_read_data[3]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [NC-1:0] rr, wr;
        ch_write_address[0] = 8'h30;
        ch_write_data[0]    = 8'h77;
        ch_write_address[1] = 8'h31;
        ch_write_data[1]    = 8'h88;
        ch_write_valid      = 4'b0011;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (wr !== 4'b0001 || cyc !== 2) begin
            errors++;
            $display("FAIL b2b_wr0: wrdy=%b cyc=%0d want 0001 2", wr, cyc);
        end
        ch_write_valid[0] = 1'b0;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (wr !== 4'b0010 || cyc !== 3) begin
            errors++;
            $display("FAIL b2b_wr1: wrdy=%b cyc=%0d want 0010 3", wr, cyc);
        end
        ch_write_valid = '0;
        idle(3);
        ch_read_address[2] = 8'h30;
        ch_read_address[3] = 8'h31;
        ch_read_valid      = 4'b1100;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b0100 || cyc !== 3 || ch_read_data[2] !== 8'h77) begin
            errors++;
            $display("FAIL b2b_rd2: rrdy=%b cyc=%0d d=%h want 0100 3 77",
                     rr, cyc, ch_read_data[2]);
        end
        ch_read_valid[2] = 1'b0;
        wait_any_ready(8, cyc, rr, wr);
        checks++;
        if (rr !== 4'b1000 || cyc !== 4 || ch_read_data[3] !== 8'h88) begin
            errors++;
            $display("FAIL b2b_rd3: rrdy=%b cyc=%0d d=%h want 1000 4 88",
                     rr, cyc, ch_read_data[3]);
        end
        ch_read_valid = '0;
        idle(3);
    endtask

    initial begin
        ch_read_valid  = '0;
        ch_write_valid = '0;
        for (int c = 0; c < NC; c++) begin
            ch_read_address[c]  = '0;
            ch_write_address[c] = '0;
            ch_write_data[c]    = '0;
        end
        test_reset();
        test_write_read();
        test_round_robin();
        test_held_valid();
        test_same_channel_rw();
        test_mid_op_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
